// File: rtl/data_sync_capture_if.sv
// Handshake bundle between the enable/data source and the capture stage.
// The master side drives the synchronized enable and the quasi-static bus;
// the slave side returns the captured bus, strobe, busy flag and glitch count.
interface data_sync_capture_if #(
    parameter int BUS_WIDTH = 8,
    parameter int GLITCH_W  = 8
);
    logic                 sync_en;
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 enable_pulse;
    logic                 busy;
    logic [GLITCH_W-1:0]  glitch_cnt;

    modport master (
        output sync_en,
        output unsync_bus,
        input  sync_bus,
        input  enable_pulse,
        input  busy,
        input  glitch_cnt
    );

    modport slave (
        input  sync_en,
        input  unsync_bus,
        output sync_bus,
        output enable_pulse,
        output busy,
        output glitch_cnt
    );
endinterface

// File: rtl/data_sync_capture.sv
// Qualifies an already-synchronized enable with a consecutive-sample filter,
// captures the quasi-static source bus once per accepted enable period and
// emits a one-cycle strobe alongside the new data. Enables that drop before
// qualification are rejected and counted in a saturating counter.
module data_sync_capture #(
    parameter int BUS_WIDTH     = 8,
    parameter int FILTER_CYCLES = 2,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    data_sync_capture_if.slave  bus
);

    // Filter length fits 4 bits (1..15); the counter never exceeds it.
    localparam logic [3:0] FILT = 4'(FILTER_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] sync_bus_q, sync_bus_d;
    logic                 pulse_q, pulse_d;
    logic                 busy_q;
    logic [GLITCH_W-1:0]  glitch_q, glitch_d;
    logic [3:0]           cnt_inc;
    logic                 capture;

    // Saturating increment: the glitch count sticks at all-ones, never wraps.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        logic [GLITCH_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(GLITCH_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    assign cnt_inc = cnt_q + 4'd1;

    // Next-state, qualification counter and capture decision.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = glitch_q;
        capture  = 1'b0;
        unique case (state_q)
            HOLD: begin
                // A low sample is required before the next transfer can start.
                if (!bus.sync_en) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (bus.sync_en) begin
                    if (FILT == 4'd1) begin
                        capture = 1'b1;
                        state_d = HOLD;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = QUAL;
                        cnt_d   = 4'd1;
                    end
                end
            end
            QUAL: begin
                if (bus.sync_en) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FILT) begin
                        capture = 1'b1;
                        state_d = HOLD;
                        cnt_d   = 4'd0;
                    end
                end else begin
                    // Enable fell before qualification: reject and count it.
                    glitch_d = sat_inc(glitch_q);
                    cnt_d    = 4'd0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = HOLD;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Data path: capture the source bus on the accepting edge, hold otherwise.
    always_comb begin
        sync_bus_d = sync_bus_q;
        pulse_d    = capture;
        if (capture) begin
            sync_bus_d = bus.unsync_bus;
        end
    end

    // State and output registers; reset has priority and lands in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            cnt_q      <= 4'd0;
            sync_bus_q <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            glitch_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_bus_q <= sync_bus_d;
            pulse_q    <= pulse_d;
            busy_q     <= (state_d == QUAL);
            glitch_q   <= glitch_d;
        end
    end

    assign bus.sync_bus     = sync_bus_q;
    assign bus.enable_pulse = pulse_q;
    assign bus.busy         = busy_q;
    assign bus.glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_data_sync_capture.sv
// Directed bench for data_sync_capture: one instance with a two-sample filter
// and one with a single-sample filter, driven from a shared vector table.
module tb_data_sync_capture;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_sync_capture_if #(.BUS_WIDTH(8), .GLITCH_W(8)) if2 ();
    data_sync_capture_if #(.BUS_WIDTH(8), .GLITCH_W(8)) if1 ();

    data_sync_capture #(.BUS_WIDTH(8), .FILTER_CYCLES(2), .GLITCH_W(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    data_sync_capture #(.BUS_WIDTH(8), .FILTER_CYCLES(1), .GLITCH_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    typedef struct {
        logic       sel;    // 0: check F=2 instance, 1: check F=1 instance
        logic       rst;
        logic       en;
        logic [7:0] bus;
        logic       pulse;
        logic [7:0] sbus;
        logic       busy;
        logic [7:0] glitch;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive inputs away from the active edge, then sample just after it.
    task automatic step(input logic r, input logic en, input logic [7:0] b);
        @(negedge clk);
        rst            = r;
        if2.sync_en    = en;
        if2.unsync_bus = b;
        if1.sync_en    = en;
        if1.unsync_bus = b;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic r, input logic en, input logic [7:0] b,
                       input logic p, input logic [7:0] sb, input logic bz,
                       input logic [7:0] g);
        vec_t v;
        v.sel = s; v.rst = r; v.en = en; v.bus = b;
        v.pulse = p; v.sbus = sb; v.busy = bz; v.glitch = g;
        tbl.push_back(v);
    endtask

    initial begin
        rst            = 1'b1;
        if2.sync_en    = 1'b0;
        if2.unsync_bus = 8'h00;
        if1.sync_en    = 1'b0;
        if1.unsync_bus = 8'h00;

        // sel rst en bus   | pulse sbus busy glitch
        // Reset with enable high: no transfer until a low sample is seen.
        add(0, 1, 1, 8'h00,  0, 8'h00, 0, 8'h00);
        for (int i = 0; i < 5; i++) add(0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'h00,  0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 8'h11,  0, 8'h00, 1, 8'h00);
        add(0, 0, 1, 8'h11,  1, 8'h11, 0, 8'h00);
        // Long high level gives exactly one pulse at edge k+1.
        add(0, 0, 0, 8'hA5,  0, 8'h11, 0, 8'h00);
        add(0, 0, 1, 8'hA5,  0, 8'h11, 1, 8'h00);
        add(0, 0, 1, 8'hA5,  1, 8'hA5, 0, 8'h00);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 8'hA5, 0, 8'hA5, 0, 8'h00);
        // One-cycle enable is a glitch: no capture, counter increments.
        add(0, 0, 0, 8'h77,  0, 8'hA5, 0, 8'h00);
        add(0, 0, 1, 8'h77,  0, 8'hA5, 1, 8'h00);
        add(0, 0, 0, 8'h77,  0, 8'hA5, 0, 8'h01);
        // Back-to-back transfers separated by one low sample.
        add(0, 0, 1, 8'h3C,  0, 8'hA5, 1, 8'h01);
        add(0, 0, 1, 8'h3C,  1, 8'h3C, 0, 8'h01);
        add(0, 0, 0, 8'h3C,  0, 8'h3C, 0, 8'h01);
        add(0, 0, 1, 8'hC3,  0, 8'h3C, 1, 8'h01);
        add(0, 0, 1, 8'hC3,  1, 8'hC3, 0, 8'h01);
        // Bus value taken at the capture edge; later changes are ignored.
        add(0, 0, 0, 8'h00,  0, 8'hC3, 0, 8'h01);
        add(0, 0, 1, 8'h00,  0, 8'hC3, 1, 8'h01);
        add(0, 0, 1, 8'h5A,  1, 8'h5A, 0, 8'h01);
        add(0, 0, 1, 8'hFF,  0, 8'h5A, 0, 8'h01);
        // Reset while busy: everything clears, HOLD requires low then high.
        add(0, 0, 0, 8'hFF,  0, 8'h5A, 0, 8'h01);
        add(0, 0, 1, 8'hEE,  0, 8'h5A, 1, 8'h01);
        add(0, 1, 1, 8'hEE,  0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 8'hEE,  0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 8'hEE,  0, 8'h00, 0, 8'h00);
        add(0, 0, 0, 8'hEE,  0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 8'h99,  0, 8'h00, 1, 8'h00);
        add(0, 0, 1, 8'h99,  1, 8'h99, 0, 8'h00);
        add(0, 0, 0, 8'h99,  0, 8'h99, 0, 8'h00);
        // Single-sample filter: pulse at the first high edge, never busy.
        add(1, 1, 1, 8'h00,  0, 8'h00, 0, 8'h00);
        add(1, 0, 1, 8'h42,  0, 8'h00, 0, 8'h00);
        add(1, 0, 0, 8'h42,  0, 8'h00, 0, 8'h00);
        add(1, 0, 1, 8'h42,  1, 8'h42, 0, 8'h00);
        add(1, 0, 1, 8'h43,  0, 8'h42, 0, 8'h00);
        add(1, 0, 0, 8'h43,  0, 8'h42, 0, 8'h00);
        add(1, 0, 1, 8'h24,  1, 8'h24, 0, 8'h00);
        add(1, 0, 0, 8'h24,  0, 8'h24, 0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].bus);
            if (tbl[i].sel == 1'b0) begin
                check("f2_pulse",  i, 32'(if2.enable_pulse), 32'(tbl[i].pulse));
                check("f2_sbus",   i, 32'(if2.sync_bus),     32'(tbl[i].sbus));
                check("f2_busy",   i, 32'(if2.busy),         32'(tbl[i].busy));
                check("f2_glitch", i, 32'(if2.glitch_cnt),   32'(tbl[i].glitch));
            end else begin
                check("f1_pulse",  i, 32'(if1.enable_pulse), 32'(tbl[i].pulse));
                check("f1_sbus",   i, 32'(if1.sync_bus),     32'(tbl[i].sbus));
                check("f1_busy",   i, 32'(if1.busy),         32'(tbl[i].busy));
                check("f1_glitch", i, 32'(if1.glitch_cnt),   32'(tbl[i].glitch));
            end
        end

        // Glitch counter saturation on the F=2 instance: reset, leave HOLD,
        // then 300 one-cycle enables; the count must stop at 255.
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("sat_start", 0, 32'(if2.glitch_cnt), 32'd0);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, 8'h6B);
            step(1'b0, 1'b0, 8'h6B);
            if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299) begin
                check("sat_glitch", i, 32'(if2.glitch_cnt),
                      (i + 1 > 255) ? 32'd255 : 32'(i + 1));
                check("sat_sbus", i, 32'(if2.sync_bus), 32'h00);
            end
            if (if2.enable_pulse) begin
                check("sat_no_pulse", i, 32'(if2.enable_pulse), 32'd0);
            end
        end
        // A full transfer after saturation still works and keeps the count.
        step(1'b0, 1'b1, 8'hD2);
        step(1'b0, 1'b1, 8'hD2);
        check("post_sat_pulse",  0, 32'(if2.enable_pulse), 32'd1);
        check("post_sat_sbus",   0, 32'(if2.sync_bus),     32'hD2);
        check("post_sat_glitch", 0, 32'(if2.glitch_cnt),   32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
